// File: rtl/fcvt_wb_queue_pkg.sv
// Shared FPU types and widths for the convert writeback path.
package fpu_pkg;

   localparam int unsigned FCVT_TAG_W   = 5;
   localparam int unsigned FCVT_LATENCY = 4;
   localparam int unsigned FCVT_DATA_W  = 32;

   // Queued regfile write: destination register and converted value.
   typedef struct packed {
      logic [FCVT_TAG_W-1:0]  rd;
      logic [FCVT_DATA_W-1:0] data;
   } fcvt_wb_entry_t;

   // One stage of the in-flight tag pipe.
   typedef struct packed {
      logic                  v;
      logic                  kill;
      logic [FCVT_TAG_W-1:0] rd;
   } fcvt_tag_t;

endpackage

// File: rtl/fcvt_wb_queue_if.sv
// Issue / converter / writeback signal bundle around the convert writeback queue.
interface fcvt_wb_queue_if;
   import fpu_pkg::*;

   logic                   issue_valid;
   logic [FCVT_TAG_W-1:0]  issue_rd;
   logic                   issue_ready;
   logic                   flush;
   logic                   cvt_valid;
   logic [FCVT_DATA_W-1:0] cvt_y;
   logic                   wb_valid;
   logic [FCVT_TAG_W-1:0]  wb_rd;
   logic [FCVT_DATA_W-1:0] wb_data;
   logic                   wb_ready;
   logic                   err_orphan;

   // Pipeline / regfile side driving the queue.
   modport master (
      output issue_valid, issue_rd, flush, cvt_valid, cvt_y, wb_ready,
      input  issue_ready, wb_valid, wb_rd, wb_data, err_orphan
   );

   // Queue side.
   modport slave (
      input  issue_valid, issue_rd, flush, cvt_valid, cvt_y, wb_ready,
      output issue_ready, wb_valid, wb_rd, wb_data, err_orphan
   );

endinterface

// File: rtl/fcvt_wb_queue_tag_pipe.sv
// Fixed-latency shift register of {v, kill, rd} tags that mirrors the converter pipe.
module fcvt_tag_pipe
   import fpu_pkg::*;
#(
   parameter int unsigned LATENCY = FCVT_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic [FCVT_TAG_W-1:0] i_rd,
   input  logic                  i_flush,
   output fcvt_tag_t             o_head
);

   fcvt_tag_t r_stage [LATENCY];
   fcvt_tag_t w_next  [LATENCY];

   // Next stage contents: new tag enters stage 0, live tags shift and pick up kill on flush.
   always_comb begin
      for (int i = 0; i < int'(LATENCY); i++) begin
         w_next[i] = '0;
      end
      w_next[0].v    = i_load;
      w_next[0].kill = 1'b0;
      w_next[0].rd   = i_load ? i_rd : '0;
      for (int i = 1; i < int'(LATENCY); i++) begin
         w_next[i]      = r_stage[i-1];
         w_next[i].kill = r_stage[i-1].kill | (i_flush & r_stage[i-1].v);
      end
   end

   // Stage registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            r_stage[i] <= w_next[i];
         end
      end
   end

   assign o_head = r_stage[LATENCY-1];

endmodule

// File: rtl/fcvt_wb_queue.sv
// Writeback queue for the FP-to-integer converters: credit-gated issue, tag/result pairing, result FIFO.
module fcvt_wb_queue
   import fpu_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LATENCY = FCVT_LATENCY
) (
   input  logic          clk,
   input  logic          rst_n,
   fcvt_wb_queue_if.slave bus
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PTR_W = IDX_W + 1;
   // Wide enough for count + in_flight, each bounded by DEPTH.
   localparam int unsigned CNT_W = $clog2(2 * DEPTH + 1);

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_in_flight;
   logic             r_err_orphan;
   fcvt_wb_entry_t   r_mem [DEPTH];

   logic [PTR_W-1:0] w_count;
   logic             w_empty;
   logic             w_full;
   logic             w_issue_ready;
   logic             w_accept;
   fcvt_tag_t        w_head;
   logic             w_kill;
   logic             w_push;
   logic             w_pop;
   logic             w_orphan;
   fcvt_wb_entry_t   w_push_entry;
   fcvt_wb_entry_t   w_head_entry;

   assign w_count = PTR_W'(r_wr_ptr - r_rd_ptr);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                    (r_wr_ptr[PTR_W-1]   != r_rd_ptr[PTR_W-1]);

   // A result slot is reserved for every op the converter might still deliver.
   assign w_issue_ready = !bus.flush &&
                          ((CNT_W'(w_count) + r_in_flight) < CNT_W'(DEPTH));
   assign w_accept      = bus.issue_valid && w_issue_ready;

   fcvt_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept),
      .i_rd    (bus.issue_rd),
      .i_flush (bus.flush),
      .o_head  (w_head)
   );

   // A result arriving in the flush cycle belongs to a killed op as well.
   assign w_kill       = w_head.kill || bus.flush;
   assign w_push       = w_head.v && !w_kill && bus.cvt_valid;
   assign w_pop        = !w_empty && bus.wb_ready && !bus.flush;
   assign w_orphan     = w_head.v != bus.cvt_valid;
   assign w_push_entry = '{rd: w_head.rd, data: bus.cvt_y};
   assign w_head_entry = r_mem[r_rd_ptr[IDX_W-1:0]];

   // FIFO pointers; flush empties the queue and overrides any pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (bus.flush) begin
         r_rd_ptr <= r_wr_ptr;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // FIFO storage; contents are only visible through non-empty pointers, so no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[IDX_W-1:0]] <= w_push_entry;
      end
   end

   // Outstanding converter ops, killed ones included until they retire at the head.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_in_flight <= '0;
      end else begin
         r_in_flight <= r_in_flight + CNT_W'(w_accept) - CNT_W'(w_head.v);
      end
   end

   // Sticky flag for a result without a tag or a tag without a result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_orphan <= 1'b0;
      end else if (w_orphan) begin
         r_err_orphan <= 1'b1;
      end
   end

   assign bus.issue_ready = w_issue_ready;
   assign bus.wb_valid    = !w_empty;
   assign bus.wb_rd       = w_empty ? '0 : w_head_entry.rd;
   assign bus.wb_data     = w_empty ? '0 : w_head_entry.data;
   assign bus.err_orphan  = r_err_orphan;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && w_full && !w_pop));

endmodule
